// File: rtl/response_builder_if.sv
// Request, DHT11 and UART-byte handshakes between response_builder and its neighbours.
interface response_builder_if;
  logic       device_selected;
  logic [7:0] request;
  logic       sensor_start;
  logic       sensor_done;
  logic       sensor_error;
  logic [7:0] temperature;
  logic [7:0] humidity;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done;
  logic       busy;
  logic       response_done;

  modport master (
    input  device_selected, request, sensor_done, sensor_error, temperature, humidity, tx_done,
    output sensor_start, tx_start, tx_data, busy, response_done
  );

  modport slave (
    output device_selected, request, sensor_done, sensor_error, temperature, humidity, tx_done,
    input  sensor_start, tx_start, tx_data, busy, response_done
  );
endinterface

// File: rtl/response_builder.sv
// Turns decoded requests into two-byte UART responses, reading the DHT11 on demand
// or periodically in continuous mode.
module response_builder #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned PERIOD_CYCLES  = 50000000
) (
  input logic                clock,
  input logic                reset,
  response_builder_if.master bus
);
  typedef enum logic [2:0] {
    IDLE, START, WAIT_SENSOR, SEND_CODE, WAIT_CODE, SEND_DATA, WAIT_DATA
  } state_t;
  typedef enum logic [1:0] {MODE_OFF, MODE_TEMP, MODE_HUM} mode_t;
  typedef enum logic [1:0] {SEL_ZERO, SEL_TEMP, SEL_HUM} sel_t;

  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] PER_LAST = 32'(PERIOD_CYCLES - 1);

  localparam logic [7:0] RSP_STATUS = 8'h07;
  localparam logic [7:0] RSP_TEMP   = 8'h08;
  localparam logic [7:0] RSP_HUM    = 8'h09;
  localparam logic [7:0] RSP_OFF5   = 8'h0A;
  localparam logic [7:0] RSP_OFF6   = 8'h0B;
  localparam logic [7:0] RSP_CTEMP  = 8'h0D;
  localparam logic [7:0] RSP_CHUM   = 8'h0E;
  localparam logic [7:0] RSP_ERR    = 8'h1F;
  localparam logic [7:0] RSP_BAD    = 8'hEF;

  state_t      state, state_n;
  mode_t       mode, mode_n;
  sel_t        sel, sel_n;
  logic        sel_q;
  logic        pend_vld, pend_vld_n;
  logic [7:0]  pend_code, pend_code_n;
  logic [7:0]  rsp_code, rsp_code_n;
  logic [7:0]  rsp_data, rsp_data_n;
  logic [31:0] to_cnt, to_cnt_n;
  logic [31:0] per_cnt, per_cnt_n;
  logic        sensor_start_q, sensor_start_n;
  logic        tx_start_q, tx_start_n;
  logic [7:0]  tx_data_q, tx_data_n;
  logic        response_done_q, response_done_n;
  logic        req_edge;
  logic [7:0]  take_code;

  assign req_edge          = bus.device_selected & ~sel_q;
  assign bus.sensor_start  = sensor_start_q;
  assign bus.tx_start      = tx_start_q;
  assign bus.tx_data       = tx_data_q;
  assign bus.busy          = (state != IDLE);
  assign bus.response_done = response_done_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      mode            <= MODE_OFF;
      sel             <= SEL_ZERO;
      sel_q           <= 1'b0;
      pend_vld        <= 1'b0;
      pend_code       <= '0;
      rsp_code        <= '0;
      rsp_data        <= '0;
      to_cnt          <= '0;
      per_cnt         <= '0;
      sensor_start_q  <= 1'b0;
      tx_start_q      <= 1'b0;
      tx_data_q       <= '0;
      response_done_q <= 1'b0;
    end else begin
      state           <= state_n;
      mode            <= mode_n;
      sel             <= sel_n;
      sel_q           <= bus.device_selected;
      pend_vld        <= pend_vld_n;
      pend_code       <= pend_code_n;
      rsp_code        <= rsp_code_n;
      rsp_data        <= rsp_data_n;
      to_cnt          <= to_cnt_n;
      per_cnt         <= per_cnt_n;
      sensor_start_q  <= sensor_start_n;
      tx_start_q      <= tx_start_n;
      tx_data_q       <= tx_data_n;
      response_done_q <= response_done_n;
    end
  end

  always_comb begin
    state_n         = state;
    mode_n          = mode;
    sel_n           = sel;
    pend_vld_n      = pend_vld;
    pend_code_n     = pend_code;
    rsp_code_n      = rsp_code;
    rsp_data_n      = rsp_data;
    to_cnt_n        = to_cnt;
    per_cnt_n       = per_cnt;
    sensor_start_n  = 1'b0;
    tx_start_n      = 1'b0;
    tx_data_n       = tx_data_q;
    response_done_n = 1'b0;
    take_code       = req_edge ? bus.request : pend_code;

    // Requests arriving mid-frame park in a one-deep slot; newest wins.
    if (req_edge && state != IDLE) begin
      pend_vld_n  = 1'b1;
      pend_code_n = bus.request;
    end

    case (state)
      IDLE: begin
        if (req_edge || pend_vld) begin
          pend_vld_n = 1'b0;
          per_cnt_n  = '0;
          rsp_data_n = '0;
          sel_n      = SEL_ZERO;
          state_n    = START;
          case (take_code)
            8'h00: rsp_code_n = RSP_STATUS;
            8'h01: begin rsp_code_n = RSP_TEMP;  sel_n = SEL_TEMP; end
            8'h02: begin rsp_code_n = RSP_HUM;   sel_n = SEL_HUM;  end
            8'h03: begin rsp_code_n = RSP_CTEMP; sel_n = SEL_TEMP; mode_n = MODE_TEMP; end
            8'h04: begin rsp_code_n = RSP_CHUM;  sel_n = SEL_HUM;  mode_n = MODE_HUM;  end
            8'h05: begin rsp_code_n = RSP_OFF5;  mode_n = MODE_OFF; state_n = SEND_CODE; end
            8'h06: begin rsp_code_n = RSP_OFF6;  mode_n = MODE_OFF; state_n = SEND_CODE; end
            default: begin rsp_code_n = RSP_BAD; state_n = SEND_CODE; end
          endcase
        end else if (mode != MODE_OFF) begin
          // Automatic read answers exactly like the enable command of the current mode.
          if (per_cnt >= PER_LAST) begin
            per_cnt_n  = '0;
            rsp_data_n = '0;
            state_n    = START;
            if (mode == MODE_TEMP) begin
              rsp_code_n = RSP_CTEMP;
              sel_n      = SEL_TEMP;
            end else begin
              rsp_code_n = RSP_CHUM;
              sel_n      = SEL_HUM;
            end
          end else begin
            per_cnt_n = per_cnt + 32'd1;
          end
        end else begin
          per_cnt_n = '0;
        end
      end
      START: begin
        sensor_start_n = 1'b1;
        to_cnt_n       = '0;
        state_n        = WAIT_SENSOR;
      end
      WAIT_SENSOR: begin
        if (bus.sensor_done) begin
          state_n = SEND_CODE;
          if (bus.sensor_error) begin
            rsp_code_n = RSP_ERR;
            rsp_data_n = '0;
          end else begin
            case (sel)
              SEL_TEMP: rsp_data_n = bus.temperature;
              SEL_HUM:  rsp_data_n = bus.humidity;
              default:  rsp_data_n = '0;
            endcase
          end
        end else if (to_cnt >= TO_LAST) begin
          rsp_code_n = RSP_ERR;
          rsp_data_n = '0;
          state_n    = SEND_CODE;
        end else begin
          to_cnt_n = to_cnt + 32'd1;
        end
      end
      SEND_CODE: begin
        tx_data_n  = rsp_code;
        tx_start_n = 1'b1;
        state_n    = WAIT_CODE;
      end
      WAIT_CODE: begin
        if (bus.tx_done) state_n = SEND_DATA;
      end
      SEND_DATA: begin
        tx_data_n  = rsp_data;
        tx_start_n = 1'b1;
        state_n    = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (bus.tx_done) begin
          response_done_n = 1'b1;
          state_n         = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_response_builder.sv
// Randomized bench for response_builder: sensor/UART responders plus a table-driven frame model.
module tb_response_builder;
  localparam int TO  = 100;
  localparam int PER = 500;

  logic clock = 1'b0;
  logic reset = 1'b1;

  response_builder_if bus ();
  response_builder #(.TIMEOUT_CYCLES(TO), .PERIOD_CYCLES(PER)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int ss_cnt = 0, ss_cyc = 0, rd_cnt = 0, rd_cyc = 0, tx_cnt = 0, done_cyc = 0;
  logic [7:0] byte_q[$];
  int         txc_q[$];

  logic       sens_respond = 1'b1;
  logic       sens_err = 1'b0;
  int         sens_delay = 5;
  logic [7:0] sens_t = 8'h00;
  logic [7:0] sens_h = 8'h00;
  int         uart_delay = 2;
  logic       hold_chk_en = 1'b1;
  int         mode_m = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic chk_win(input string tag, input int got, input int lo, input int hi);
    chk(tag, (got >= lo && got <= hi) ? 32'(lo) : 32'(got), 32'(lo));
  endtask

  // Reference: response table by request code.
  function automatic logic [15:0] exp_frame(input logic [7:0] code, input logic fail,
                                            input logic [7:0] t, input logic [7:0] h);
    case (code)
      8'h00: return fail ? 16'h1F00 : 16'h0700;
      8'h01: return fail ? 16'h1F00 : {8'h08, t};
      8'h02: return fail ? 16'h1F00 : {8'h09, h};
      8'h03: return fail ? 16'h1F00 : {8'h0D, t};
      8'h04: return fail ? 16'h1F00 : {8'h0E, h};
      8'h05: return 16'h0A00;
      8'h06: return 16'h0B00;
      default: return 16'hEF00;
    endcase
  endfunction

  function automatic int next_mode(input logic [7:0] code, input int m);
    case (code)
      8'h03: return 1;
      8'h04: return 2;
      8'h05, 8'h06: return 0;
      default: return m;
    endcase
  endfunction

  always @(posedge clock) begin
    cyc++;
    #1;
    if (bus.sensor_start) begin ss_cnt++; ss_cyc = cyc; end
    if (bus.tx_start) tx_cnt++;
    if (bus.response_done) begin rd_cnt++; rd_cyc = cyc; end
  end

  // DHT11 stand-in; data lines carry junk outside the done pulse.
  initial begin
    bus.sensor_done = 1'b0; bus.sensor_error = 1'b0;
    bus.temperature = 8'h00; bus.humidity = 8'h00;
    forever begin
      @(negedge clock);
      if (bus.sensor_start && sens_respond) begin
        repeat (sens_delay) @(negedge clock);
        bus.temperature = sens_t; bus.humidity = sens_h;
        bus.sensor_error = sens_err; bus.sensor_done = 1'b1; done_cyc = cyc;
        @(negedge clock);
        bus.sensor_done = 1'b0; bus.sensor_error = 1'b0;
        bus.temperature = 8'($urandom); bus.humidity = 8'($urandom);
      end
    end
  end

  // UART stand-in.
  initial begin
    logic [7:0] b;
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clock);
      if (bus.tx_start) begin
        b = bus.tx_data;
        byte_q.push_back(b);
        txc_q.push_back(cyc);
        repeat (uart_delay) @(negedge clock);
        if (hold_chk_en) chk("tx_hold", 32'(bus.tx_data), 32'(b));
        bus.tx_done = 1'b1;
        @(negedge clock);
        bus.tx_done = 1'b0;
      end
    end
  end

  task automatic send_req(input logic [7:0] code, input int hold);
    bus.request = code;
    bus.device_selected = 1'b1;
    repeat (hold) @(negedge clock);
    bus.device_selected = 1'b0;
  endtask

  task automatic wait_frame(input string tag, input int rd0, input logic [15:0] exp, output int ftx);
    int n;
    logic [15:0] got;
    n = 0;
    got = 16'hDEAD;
    while (rd_cnt == rd0 && n < 2000) begin @(negedge clock); n++; end
    chk({tag, "_rdone"}, 32'(rd_cnt - rd0), 32'd1);
    chk({tag, "_nbytes"}, 32'(byte_q.size()), 32'd2);
    ftx = (txc_q.size() > 0) ? txc_q[0] : -1000;
    if (byte_q.size() >= 2) got = {byte_q[0], byte_q[1]};
    chk(tag, 32'(got), 32'(exp));
    byte_q.delete();
    txc_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0, ss0, c0, ftx, rp, tx0, n;
    logic [7:0] code;
    bus.device_selected = 1'b0;
    bus.request = 8'h00;
    repeat (3) @(negedge clock);
    chk("rst_sensor_start", 32'(bus.sensor_start), 32'd0);
    chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_rdone", 32'(bus.response_done), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Temperature read with known data.
    sens_delay = 20; sens_t = 8'h19; sens_err = 1'b0; uart_delay = 3;
    rd0 = rd_cnt; c0 = cyc;
    send_req(8'h01, 2);
    wait_frame("temp", rd0, 16'h0819, ftx);
    chk_win("req2start", ss_cyc - c0, 2, 3);
    chk("done2tx", 32'(ftx - done_cyc), 32'd2);

    // Randomized single-shot requests (mode stays off).
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 5))
        0: code = 8'h00;
        1: code = 8'h01;
        2: code = 8'h02;
        3: code = 8'h05;
        4: code = 8'h06;
        default: code = 8'($urandom_range(7, 255));
      endcase
      sens_respond = ($urandom_range(0, 9) != 0);
      sens_err = ($urandom_range(0, 5) == 0);
      sens_delay = $urandom_range(1, 40);
      sens_t = 8'($urandom); sens_h = 8'($urandom);
      uart_delay = $urandom_range(1, 6);
      ss0 = ss_cnt; rd0 = rd_cnt;
      send_req(code, $urandom_range(1, 4));
      wait_frame("rand", rd0, exp_frame(code, !sens_respond || sens_err, sens_t, sens_h), ftx);
      chk("rand_starts", 32'(ss_cnt - ss0), (code <= 8'h04) ? 32'd1 : 32'd0);
      mode_m = next_mode(code, mode_m);
      repeat ($urandom_range(1, 5)) @(negedge clock);
    end

    // Timeout, no retry.
    sens_respond = 1'b0; ss0 = ss_cnt; rd0 = rd_cnt;
    send_req(8'h02, 1);
    wait_frame("timeout", rd0, 16'h1F00, ftx);
    chk_win("timeout_len", ftx - ss_cyc, TO, TO + 2);
    repeat (200) @(negedge clock);
    chk("timeout_noretry", 32'(ss_cnt - ss0), 32'd1);
    sens_respond = 1'b1; sens_err = 1'b0;

    // Continuous temperature.
    sens_t = 8'h1A; sens_delay = $urandom_range(1, 30); uart_delay = 2;
    rd0 = rd_cnt;
    send_req(8'h03, 1);
    mode_m = next_mode(8'h03, mode_m);
    wait_frame("ctemp", rd0, exp_frame(8'h03, 1'b0, sens_t, sens_h), ftx);
    for (int k = 0; k < 2; k++) begin
      rd0 = rd_cnt; rp = rd_cyc;
      wait_frame("auto_temp", rd0, (mode_m == 1) ? {8'h0D, sens_t} : {8'h0E, sens_h}, ftx);
      chk_win("auto_temp_period", ss_cyc - rp, PER, PER + 2);
    end
    rd0 = rd_cnt;
    send_req(8'h05, 1);
    mode_m = next_mode(8'h05, mode_m);
    wait_frame("off5", rd0, 16'h0A00, ftx);
    ss0 = ss_cnt;
    repeat (2000) @(negedge clock);
    chk("off_nostart", 32'(ss_cnt - ss0), 32'd0);

    // Unknown code held high for 50 cycles.
    ss0 = ss_cnt; rd0 = rd_cnt;
    send_req(8'h7F, 50);
    wait_frame("bad", rd0, 16'hEF00, ftx);
    repeat (20) @(negedge clock);
    chk("bad_oneframe", 32'(rd_cnt - rd0), 32'd1);
    chk("bad_nostart", 32'(ss_cnt - ss0), 32'd0);

    // Humidity mode, request coinciding with period expiry, then a request parked mid-frame.
    sens_h = 8'($urandom); sens_t = 8'($urandom); sens_delay = 10; uart_delay = 4;
    rd0 = rd_cnt;
    send_req(8'h04, 1);
    mode_m = next_mode(8'h04, mode_m);
    wait_frame("chum", rd0, exp_frame(8'h04, 1'b0, sens_t, sens_h), ftx);
    while (cyc < rd_cyc + PER - 1) @(negedge clock);
    ss0 = ss_cnt; rd0 = rd_cnt;
    send_req(8'h00, 1);
    n = 0;
    while (!bus.tx_start && n < 300) begin @(negedge clock); n++; end
    send_req(8'h01, 1);
    wait_frame("coinc_status", rd0, 16'h0700, ftx);
    chk("coinc_starts", 32'(ss_cnt - ss0), 32'd1);
    rd0 = rd_cnt;
    wait_frame("pending", rd0, exp_frame(8'h01, 1'b0, sens_t, sens_h), ftx);
    rd0 = rd_cnt; rp = rd_cyc;
    wait_frame("auto_hum", rd0, (mode_m == 2) ? {8'h0E, sens_h} : {8'h0D, sens_t}, ftx);
    chk_win("auto_hum_period", ss_cyc - rp, PER, PER + 2);

    // Reset during the data byte with mode TEMP.
    uart_delay = 6; hold_chk_en = 1'b0;
    tx0 = tx_cnt;
    send_req(8'h03, 1);
    n = 0;
    while (tx_cnt - tx0 < 2 && n < 500) begin @(negedge clock); n++; end
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_sensor_start", 32'(bus.sensor_start), 32'd0);
    chk("mid_rst_tx_start", 32'(bus.tx_start), 32'd0);
    chk("mid_rst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_rdone", 32'(bus.response_done), 32'd0);
    reset = 1'b0;
    rd0 = rd_cnt; ss0 = ss_cnt;
    repeat (1000) @(negedge clock);
    chk("post_rst_nordone", 32'(rd_cnt - rd0), 32'd0);
    chk("post_rst_nostart", 32'(ss_cnt - ss0), 32'd0);
    byte_q.delete(); txc_q.delete();
    hold_chk_en = 1'b1;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
